// File: rtl/pico_pkg.sv
// Shared pico-MIPS types.
//   br_cond_t  : branch condition encoding as delivered by the decoder
//   br_state_t : branch unit FSM states
package pico_pkg;

  typedef enum logic [1:0] {
    ALWAYS = 2'b00,
    IF_Z   = 2'b01,
    IF_NZ  = 2'b10,
    IF_N   = 2'b11
  } br_cond_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    TAKE = 2'b10
  } br_state_t;

endpackage

// File: rtl/branch_unit.sv
// Branch resolution unit: accepts a decoded branch, waits for the ALU
// flags when the branch is conditional, then steers the PC through the
// relative-branch interface.
//   clk, reset        : clock, async active-high reset
//   br_valid/cond/    : branch from the decoder (offset relative to the
//   br_offset           branch's own address)
//   flags_valid/z/n   : ALU condition flags
//   rel_branch/offset : to PC; offset 0 holds the PC, off_m1 jumps
//   squash            : discard the instruction fetched behind the branch
//   busy              : a branch is in flight
//   timeout           : one-cycle pulse when waiting for flags gave up
module branch_unit
  import pico_pkg::*;
#(
  parameter int AddrSz  = 6,
  parameter int MaxWait = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              br_valid,
  input  logic [1:0]        br_cond,
  input  logic [AddrSz-1:0] br_offset,
  input  logic              flags_valid,
  input  logic              flag_z,
  input  logic              flag_n,
  output logic              rel_branch,
  output logic [AddrSz-1:0] offset,
  output logic              squash,
  output logic              busy,
  output logic              timeout
);

  localparam int CntW = $clog2(MaxWait + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxWait);

  br_state_t         state, state_nxt;
  br_cond_t          cond_q;
  logic [AddrSz-1:0] off_m1;
  logic [CntW-1:0]   wait_cnt;
  logic [CntW-1:0]   cnt_inc;
  logic              taken;
  logic              timeout_nxt;

  assign cnt_inc = wait_cnt + 1'b1;

  always_comb begin
    taken = 1'b0;
    unique case (cond_q)
      ALWAYS: taken = 1'b1;
      IF_Z:   taken = flag_z;
      IF_NZ:  taken = ~flag_z;
      IF_N:   taken = flag_n;
    endcase
  end

  // Next state. Flags seen in IDLE belong to older instructions and a
  // br_valid outside IDLE comes from a squashed slot, so both are ignored.
  always_comb begin
    state_nxt   = state;
    timeout_nxt = 1'b0;
    unique case (state)
      IDLE: if (br_valid)
              state_nxt = (br_cond_t'(br_cond) == ALWAYS) ? TAKE : WAIT;
      WAIT: begin
        if (flags_valid) begin
          state_nxt = taken ? TAKE : IDLE;
        end else if (cnt_inc == MaxCnt) begin
          state_nxt   = IDLE;
          timeout_nxt = 1'b1;
        end
      end
      TAKE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cond_q   <= ALWAYS;
      off_m1   <= '0;
      wait_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      state   <= state_nxt;
      timeout <= timeout_nxt;
      if (state == IDLE && br_valid) begin
        cond_q   <= br_cond_t'(br_cond);
        // PC is already one past the branch when the jump is applied.
        off_m1   <= br_offset - 1'b1;
        wait_cnt <= '0;
      end else if (state == WAIT && !flags_valid) begin
        wait_cnt <= cnt_inc;
      end
    end
  end

  // Moore outputs; WAIT drives offset 0 so the PC holds in place.
  always_comb begin
    rel_branch = 1'b0;
    offset     = '0;
    squash     = 1'b0;
    busy       = 1'b0;
    unique case (state)
      WAIT: begin
        rel_branch = 1'b1;
        squash     = 1'b1;
        busy       = 1'b1;
      end
      TAKE: begin
        rel_branch = 1'b1;
        offset     = off_m1;
        squash     = 1'b1;
        busy       = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit (AddrSz=6, MaxWait=4) with a small PC
// model driven by rel_branch/offset.
module tb_branch_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       br_valid;
  logic [1:0] br_cond;
  logic [5:0] br_offset;
  logic       flags_valid, flag_z, flag_n;
  logic       rel_branch, squash, busy, timeout;
  logic [5:0] offset;

  logic       ld;
  logic [5:0] ld_val;
  logic [5:0] pc;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_unit #(.AddrSz(6), .MaxWait(4)) dut (
    .clk(clk), .reset(reset),
    .br_valid(br_valid), .br_cond(br_cond), .br_offset(br_offset),
    .flags_valid(flags_valid), .flag_z(flag_z), .flag_n(flag_n),
    .rel_branch(rel_branch), .offset(offset), .squash(squash),
    .busy(busy), .timeout(timeout)
  );

  // PC: relative add when rel_branch, otherwise increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           pc <= '0;
    else if (ld)         pc <= ld_val;
    else if (rel_branch) pc <= pc + offset;
    else                 pc <= pc + 6'd1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic r, input logic [5:0] o,
                         input logic s, input logic b);
    chk({tag, ".rel"},    32'(rel_branch), 32'(r));
    chk({tag, ".offset"}, 32'(offset),     32'(o));
    chk({tag, ".squash"}, 32'(squash),     32'(s));
    chk({tag, ".busy"},   32'(busy),       32'(b));
  endtask

  task automatic set_pc(input logic [5:0] a);
    ld = 1'b1; ld_val = a;
    tick();
    ld = 1'b0;
  endtask

  // Present a branch for one edge (the accept edge k).
  task automatic issue(input logic [1:0] c, input logic [5:0] off);
    br_valid = 1'b1; br_cond = c; br_offset = off;
    tick();
    br_valid = 1'b0; br_cond = 2'b00; br_offset = '0;
  endtask

  initial begin
    reset = 1'b1; br_valid = 0; br_cond = 0; br_offset = 0;
    flags_valid = 0; flag_z = 0; flag_n = 0; ld = 0; ld_val = 0;
    #1;
    chk_out("reset", 0, 0, 0, 0);
    chk("reset.timeout", 32'(timeout), 0);
    #12 reset = 1'b0;
    tick();
    chk_out("idle", 0, 0, 0, 0);

    // ALWAYS, A=5, offset 10 -> target 15
    set_pc(6'd5);
    issue(2'b00, 6'd10);
    chk_out("always.take", 1, 6'd9, 1, 1);
    chk("always.pc_k", 32'(pc), 6);
    tick();
    chk("always.pc_tgt", 32'(pc), 15);
    chk_out("always.idle", 0, 0, 0, 0);

    // IF_Z taken after 3 cycles, A=20, offset -4 -> target 16
    set_pc(6'd20);
    issue(2'b01, 6'h3C);
    chk_out("ifz.wait0", 1, 0, 1, 1);
    chk("ifz.pc0", 32'(pc), 21);
    tick();
    chk("ifz.pc1", 32'(pc), 21);
    tick();
    chk("ifz.pc2", 32'(pc), 21);
    flags_valid = 1; flag_z = 1;
    tick();
    flags_valid = 0; flag_z = 0;
    chk_out("ifz.take", 1, 6'h3B, 1, 1);
    chk("ifz.pc3", 32'(pc), 21);
    tick();
    chk("ifz.pc_tgt", 32'(pc), 16);
    chk("ifz.idle", 32'(busy), 0);

    // IF_NZ not taken on first WAIT edge, A=8
    set_pc(6'd8);
    issue(2'b10, 6'd7);
    chk_out("ifnz.wait", 1, 0, 1, 1);
    flags_valid = 1; flag_z = 1;
    tick();
    flags_valid = 0; flag_z = 0;
    chk_out("ifnz.idle", 0, 0, 0, 0);
    chk("ifnz.pc9", 32'(pc), 9);
    tick();
    chk("ifnz.pc10", 32'(pc), 10);
    tick();
    chk("ifnz.pc11", 32'(pc), 11);

    // IF_NZ taken (flag_z=0), A=12, offset 3 -> 15
    set_pc(6'd12);
    issue(2'b10, 6'd3);
    flags_valid = 1; flag_z = 0;
    tick();
    flags_valid = 0;
    chk_out("ifnz_t.take", 1, 6'd2, 1, 1);
    tick();
    chk("ifnz_t.pc", 32'(pc), 15);

    // IF_N taken with flag_n=1, flag_z=1 irrelevant; A=2, offset 5 -> 7
    set_pc(6'd2);
    issue(2'b11, 6'd5);
    flags_valid = 1; flag_n = 1; flag_z = 1;
    tick();
    flags_valid = 0; flag_n = 0; flag_z = 0;
    chk_out("ifn_t.take", 1, 6'd4, 1, 1);
    tick();
    chk("ifn_t.pc", 32'(pc), 7);

    // IF_N timeout: 4 WAIT cycles then a single timeout pulse; A=40
    set_pc(6'd40);
    issue(2'b11, 6'd9);
    chk("to.t0", 32'(timeout), 0);
    // br_valid while waiting is ignored
    br_valid = 1; br_cond = 2'b00; br_offset = 6'd20;
    tick();
    br_valid = 0; br_cond = 0; br_offset = 0;
    chk_out("to.w1", 1, 0, 1, 1);
    tick();
    chk("to.busy2", 32'(busy), 1);
    tick();
    chk("to.busy3", 32'(busy), 1);
    chk("to.t3", 32'(timeout), 0);
    tick();
    chk_out("to.idle", 0, 0, 0, 0);
    chk("to.pulse", 32'(timeout), 1);
    chk("to.pc_hold", 32'(pc), 41);
    tick();
    chk("to.pulse_end", 32'(timeout), 0);
    chk("to.pc_resume", 32'(pc), 42);

    // Wrap: A=60, ALWAYS, offset 10 -> 6
    set_pc(6'd60);
    issue(2'b00, 6'd10);
    tick();
    chk("wrap.pc", 32'(pc), 6);

    // Branch to self: A=30, offset 0 -> off_m1 = 63
    set_pc(6'd30);
    issue(2'b00, 6'd0);
    chk_out("self.take", 1, 6'd63, 1, 1);
    tick();
    chk("self.pc", 32'(pc), 30);

    // Offset 1: continue at A+1
    set_pc(6'd33);
    issue(2'b00, 6'd1);
    chk("next.off", 32'(offset), 0);
    tick();
    chk("next.pc", 32'(pc), 34);

    // br_valid and flags_valid together in IDLE: flags ignored, enter WAIT
    set_pc(6'd50);
    flags_valid = 1; flag_z = 1;
    issue(2'b01, 6'd4);
    flags_valid = 0; flag_z = 0;
    chk_out("both.wait", 1, 0, 1, 1);
    flags_valid = 1; flag_z = 0;
    tick();
    flags_valid = 0;
    chk_out("both.nt", 0, 0, 0, 0);

    // Reset mid-WAIT, outputs drop before the next edge
    issue(2'b01, 6'd4);
    chk("rst.busy_pre", 32'(busy), 1);
    #2 reset = 1'b1;
    #1;
    chk_out("rst.async", 0, 0, 0, 0);
    #2 reset = 1'b0;
    tick();
    chk_out("rst.idle", 0, 0, 0, 0);
    set_pc(6'd10);
    issue(2'b00, 6'd2);
    chk_out("rst.accept", 1, 6'd1, 1, 1);
    tick();
    chk("rst.pc", 32'(pc), 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
